// File: rtl/oct_sram_pkg.sv
// Shared types and derived widths for the banked Octree scratchpad.
// OCT_SRAM_ERR_EN (optional) enables out-of-range detection in oct_sram_banked.
package oct_sram_pkg;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 64;

  localparam int BANK_SEL_W = (DEF_NUM_BANKS > 1) ? $clog2(DEF_NUM_BANKS) : 1;
  localparam int ROW_W      = DEF_ADDR_WIDTH - BANK_SEL_W;

  typedef struct packed {
    logic                            we;
    logic [DEF_DATA_WIDTH/8-1:0]     be;
    logic [ROW_W+BANK_SEL_W-1:0]     addr;
    logic [DEF_DATA_WIDTH-1:0]       wdata;
  } oct_sram_req_t;

  typedef struct packed {
    logic                      rvalid;
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } oct_sram_rsp_t;

  // Index width for n items, never zero so single-item configs stay legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oct_sram_bank.sv
// One single-port bank: byte-enable write on the access edge, registered read.
module oct_sram_bank
  import oct_sram_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int ROW_W      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ROW_W-1:0]        i_row,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (i_be[i]) begin
          r_mem[i_row][i*8 +: 8] <= i_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_row];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/oct_sram_banked.sv
// Multi-port, word-interleaved banked scratchpad with per-bank round-robin arbitration.
// Define OCT_SRAM_ERR_EN to flag and suppress accesses at or above MEM_DEPTH.
module oct_sram_banked
  import oct_sram_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = 4096,
  parameter int READ_LAT   = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     rdata_o,
  output logic [NUM_PORTS-1:0]                err_o
);

  localparam int BE_W       = DATA_WIDTH / 8;
  localparam int LOG2NB     = $clog2(NUM_BANKS);
  localparam int BANK_DEPTH = MEM_DEPTH / NUM_BANKS;
  localparam int BIW        = sel_width(NUM_BANKS);
  localparam int PIW        = sel_width(NUM_PORTS);
  localparam int RIW        = sel_width(BANK_DEPTH);

  logic [BIW-1:0]        w_bank [NUM_PORTS];
  logic [RIW-1:0]        w_row  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_oor;
  logic [NUM_PORTS-1:0]  w_gnt;

  logic [PIW-1:0]        r_ptr  [NUM_BANKS];
  logic [PIW-1:0]        w_win  [NUM_BANKS];
  logic [NUM_BANKS-1:0]  w_bank_en;
  logic [NUM_BANKS-1:0]  w_adv;

  logic [NUM_BANKS-1:0]  w_b_we;
  logic [BE_W-1:0]       w_b_be    [NUM_BANKS];
  logic [RIW-1:0]        w_b_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_b_wdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_b_rdata [NUM_BANKS];

  logic [NUM_PORTS-1:0]  r_v1;
  logic [NUM_PORTS-1:0]  r_rd1;
  logic [NUM_PORTS-1:0]  r_err1;
  logic [BIW-1:0]        r_bank1    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_hold     [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_s1_rdata [NUM_PORTS];

  // Split each port address into bank, wrapped row and range flag
  always_comb begin
    int v_a;
    v_a = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      v_a       = int'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
      w_bank[p] = BIW'(v_a % NUM_BANKS);
      w_row[p]  = RIW'((v_a >> LOG2NB) % BANK_DEPTH);
`ifdef OCT_SRAM_ERR_EN
      w_oor[p]  = (v_a >= MEM_DEPTH);
`else
      w_oor[p]  = 1'b0;
`endif
    end
  end

  // Per-bank scan from the pointer; count contenders to decide pointer movement
  always_comb begin
    int v_idx;
    int v_cnt;
    v_idx     = 0;
    v_cnt     = 0;
    w_gnt     = '0;
    w_bank_en = '0;
    w_adv     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_win[b] = '0;
      v_cnt    = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        v_idx = (int'(r_ptr[b]) + k) % NUM_PORTS;
        if (req_i[v_idx] && (int'(w_bank[v_idx]) == b)) begin
          if (v_cnt == 0) begin
            w_win[b] = PIW'(v_idx);
          end else begin
            w_win[b] = w_win[b];
          end
          v_cnt = v_cnt + 1;
        end else begin
          v_cnt = v_cnt;
        end
      end
      if (v_cnt > 0) begin
        w_bank_en[b]    = 1'b1;
        w_gnt[w_win[b]] = 1'b1;
      end else begin
        w_bank_en[b]    = 1'b0;
      end
      w_adv[b] = (v_cnt > 1);
    end
  end

  // Route the winning port onto each bank; out-of-range writes lose all byte enables
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_b_we[b]    = we_i[w_win[b]];
      w_b_row[b]   = w_row[w_win[b]];
      w_b_wdata[b] = wdata_i[int'(w_win[b])*DATA_WIDTH +: DATA_WIDTH];
      if (w_oor[w_win[b]]) begin
        w_b_be[b] = '0;
      end else begin
        w_b_be[b] = be_i[int'(w_win[b])*BE_W +: BE_W];
      end
    end
  end

  // Round-robin pointers move past the winner only after real contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_adv[b]) r_ptr[b] <= PIW'((int'(w_win[b]) + 1) % NUM_PORTS);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    oct_sram_bank #(
      .DEPTH      (BANK_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_W      (RIW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_bank_en[b]),
      .i_we    (w_b_we[b]),
      .i_be    (w_b_be[b]),
      .i_row   (w_b_row[b]),
      .i_wdata (w_b_wdata[b]),
      .o_rdata (w_b_rdata[b])
    );
  end

  // Read responses pick up bank data; write responses keep the previous read data
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_v1[p] && r_rd1[p]) begin
        w_s1_rdata[p] = r_err1[p] ? '0 : w_b_rdata[r_bank1[p]];
      end else begin
        w_s1_rdata[p] = r_hold[p];
      end
    end
  end

  // First return stage: which bank each port's response comes from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= '0;
      r_rd1  <= '0;
      r_err1 <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_bank1[p] <= '0;
        r_hold[p]  <= '0;
      end
    end else begin
      r_v1   <= w_gnt;
      r_rd1  <= ~we_i;
      r_err1 <= w_oor;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_bank1[p] <= w_bank[p];
        r_hold[p]  <= w_s1_rdata[p];
      end
    end
  end

  assign gnt_o = w_gnt;

  if (READ_LAT == 2) begin : g_lat2
    logic [NUM_PORTS-1:0] r_v2;
    logic [NUM_PORTS-1:0] r_err2;

    // r_hold already trails stage one by a cycle, so it doubles as the output data register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v2   <= '0;
        r_err2 <= '0;
      end else begin
        r_v2   <= r_v1;
        r_err2 <= r_v1 & r_err1;
      end
    end

    assign rvalid_o = r_v2;
    assign err_o    = r_err2;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
      assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_hold[p];
    end
  end else begin : g_lat1
    assign rvalid_o = r_v1;
    assign err_o    = r_v1 & r_err1;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
      assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = w_s1_rdata[p];
    end
  end

endmodule

// File: tb/tb_oct_sram_banked.sv
// Directed bench: a READ_LAT=1 instance driven from a vector table and a
// READ_LAT=2, 13-bit-address instance for latency, range and reset sequences.
module tb_oct_sram_banked;
  import oct_sram_pkg::*;

`ifdef OCT_SRAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam logic [63:0] DA = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] DP = 64'h11111111_22222222;
  localparam logic [63:0] DM = 64'hDEADBEEF_22222222;
  localparam logic [63:0] D1 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] D2 = 64'h0202_0202_0202_0202;
  localparam logic [63:0] D8 = 64'h0808_0808_0808_0808;
  localparam logic [63:0] A2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] B2 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] C2 = 64'h0C0C_0C0C_0C0C_0C0C;
  localparam logic [63:0] E2 = 64'h0D0D_0D0D_0D0D_0D0D;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   req, gnt, we, rvalid, err;
  logic [15:0]  be;
  logic [23:0]  addr;
  logic [127:0] wdata, rdata;

  logic [1:0]   req2, gnt2, we2, rvalid2, err2;
  logic [15:0]  be2;
  logic [25:0]  addr2;
  logic [127:0] wdata2, rdata2;

  int total = 0;
  int bad   = 0;

  oct_sram_banked dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  oct_sram_banked #(.ADDR_WIDTH(13), .MEM_DEPTH(4096), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req2), .gnt_o(gnt2), .we_i(we2), .be_i(be2),
    .addr_i(addr2), .wdata_i(wdata2), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
  );

  typedef struct {
    logic [1:0]    req;
    oct_sram_req_t p0;
    oct_sram_req_t p1;
    logic [1:0]    gnt;
    logic [1:0]    rv;
    logic [63:0]   rd0;
    logic [63:0]   rd1;
  } vec_t;

  vec_t vt [13];

  function automatic oct_sram_req_t rq(input logic w, input logic [7:0] b,
                                       input logic [11:0] a, input logic [63:0] d);
    oct_sram_req_t r;
    r.we = w; r.be = b; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle on dut2: port 0 read/write, port 1 read; checks grant then the response edge
  task automatic d2(input logic [1:0] rq2, input logic w0, input logic [12:0] a0,
                    input logic [63:0] d0, input logic [12:0] a1, input logic [1:0] eg,
                    input logic [1:0] erv, input logic [63:0] erd, input logic eerr,
                    input string nm);
    req2 = rq2; we2 = {1'b0, w0}; be2 = 16'hFFFF;
    addr2 = {a1, a0}; wdata2 = {64'h0, d0};
    @(negedge clk);
    chk({nm, " gnt"}, 64'(gnt2), 64'(eg));
    @(posedge clk); #1;
    chk({nm, " rvalid"}, 64'(rvalid2), 64'(erv));
    chk({nm, " rdata"}, rdata2[63:0], erd);
    chk({nm, " err"}, 64'(err2[0]), 64'(eerr));
  endtask

  initial begin
    oct_sram_req_t idle;
    idle = rq(1'b0, 8'hFF, 12'd0, 64'h0);
    vt[0]  = '{2'b01, rq(1'b1, 8'hFF, 12'd5, DA), idle, 2'b01, 2'b01, 64'h0, 64'h0};
    vt[1]  = '{2'b01, rq(1'b0, 8'hFF, 12'd5, 64'h0), idle, 2'b01, 2'b01, DA, 64'h0};
    vt[2]  = '{2'b01, rq(1'b1, 8'h0F, 12'd5, DP), idle, 2'b01, 2'b01, DA, 64'h0};
    vt[3]  = '{2'b01, rq(1'b0, 8'hFF, 12'd5, 64'h0), idle, 2'b01, 2'b01, DM, 64'h0};
    vt[4]  = '{2'b11, rq(1'b1, 8'hFF, 12'd8, D8), rq(1'b1, 8'hFF, 12'd2, D2),
               2'b11, 2'b11, DM, 64'h0};
    vt[5]  = '{2'b11, rq(1'b1, 8'hFF, 12'd1, D1), rq(1'b1, 8'h00, 12'd2, ONES),
               2'b11, 2'b11, DM, 64'h0};
    vt[6]  = '{2'b11, rq(1'b0, 8'hFF, 12'd1, 64'h0), rq(1'b0, 8'hFF, 12'd2, 64'h0),
               2'b11, 2'b11, D1, D2};
    vt[7]  = '{2'b11, rq(1'b0, 8'hFF, 12'd8, 64'h0), rq(1'b0, 8'hFF, 12'd8, 64'h0),
               2'b01, 2'b01, D8, D2};
    vt[8]  = '{2'b11, rq(1'b0, 8'hFF, 12'd8, 64'h0), rq(1'b0, 8'hFF, 12'd8, 64'h0),
               2'b10, 2'b10, D8, D8};
    vt[9]  = '{2'b11, rq(1'b0, 8'hFF, 12'd8, 64'h0), rq(1'b0, 8'hFF, 12'd8, 64'h0),
               2'b01, 2'b01, D8, D8};
    vt[10] = '{2'b10, idle, rq(1'b0, 8'hFF, 12'd8, 64'h0), 2'b10, 2'b10, D8, D8};
    vt[11] = '{2'b11, rq(1'b0, 8'hFF, 12'd8, 64'h0), rq(1'b0, 8'hFF, 12'd8, 64'h0),
               2'b10, 2'b10, D8, D8};
    vt[12] = '{2'b11, rq(1'b0, 8'hFF, 12'd8, 64'h0), rq(1'b0, 8'hFF, 12'd8, 64'h0),
               2'b01, 2'b01, D8, D8};

    rst_n = 1'b0;
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    req2 = '0; we2 = '0; be2 = '0; addr2 = '0; wdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rvalid", 64'(rvalid), 64'd0);
    chk("reset rdata", rdata[63:0], 64'h0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset rvalid2", 64'(rvalid2), 64'd0);
    chk("reset rdata2", rdata2[63:0], 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      req   = vt[i].req;
      we    = {vt[i].p1.we, vt[i].p0.we};
      be    = {vt[i].p1.be, vt[i].p0.be};
      addr  = {vt[i].p1.addr, vt[i].p0.addr};
      wdata = {vt[i].p1.wdata, vt[i].p0.wdata};
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), 64'(gnt), 64'(vt[i].gnt));
      @(posedge clk); #1;
      chk($sformatf("v%0d rvalid", i), 64'(rvalid), 64'(vt[i].rv));
      chk($sformatf("v%0d rdata0", i), rdata[63:0], vt[i].rd0);
      chk($sformatf("v%0d rdata1", i), rdata[127:64], vt[i].rd1);
      chk($sformatf("v%0d err", i), 64'(err), 64'd0);
    end
    req = '0; we = '0;

    // READ_LAT=2: ordering, write visibility and back-to-back reads
    d2(2'b01, 1'b1, 13'd3, A2, 13'd0, 2'b01, 2'b00, 64'h0, 1'b0, "l2 s0");
    d2(2'b01, 1'b0, 13'd3, 64'h0, 13'd0, 2'b01, 2'b01, 64'h0, 1'b0, "l2 s1");
    d2(2'b01, 1'b1, 13'd3, B2, 13'd0, 2'b01, 2'b01, A2, 1'b0, "l2 s2");
    d2(2'b01, 1'b0, 13'd3, 64'h0, 13'd0, 2'b01, 2'b01, A2, 1'b0, "l2 s3");
    d2(2'b01, 1'b0, 13'd3, 64'h0, 13'd0, 2'b01, 2'b01, B2, 1'b0, "l2 s4");
    d2(2'b01, 1'b0, 13'd3, 64'h0, 13'd0, 2'b01, 2'b01, B2, 1'b0, "l2 s5");
    d2(2'b01, 1'b0, 13'd3, 64'h0, 13'd0, 2'b01, 2'b01, B2, 1'b0, "l2 s6");
    d2(2'b00, 1'b0, 13'd0, 64'h0, 13'd0, 2'b00, 2'b01, B2, 1'b0, "l2 s7");
    d2(2'b00, 1'b0, 13'd0, 64'h0, 13'd0, 2'b00, 2'b00, B2, 1'b0, "l2 s8");

    // Address 4096: aliases row 0 of bank 0, or is flagged and suppressed
    d2(2'b01, 1'b1, 13'd0, C2, 13'd0, 2'b01, 2'b00, B2, 1'b0, "rng s0");
    d2(2'b01, 1'b1, 13'd4096, E2, 13'd0, 2'b01, 2'b01, B2, 1'b0, "rng s1");
    d2(2'b01, 1'b0, 13'd4096, 64'h0, 13'd0, 2'b01, 2'b01, B2, ERR, "rng s2");
    d2(2'b01, 1'b0, 13'd0, 64'h0, 13'd0, 2'b01, 2'b01, ERR ? 64'h0 : E2, ERR, "rng s3");
    d2(2'b00, 1'b0, 13'd0, 64'h0, 13'd0, 2'b00, 2'b01, ERR ? C2 : E2, 1'b0, "rng s4");

    // Reset between grant and response discards it and clears the pointers
    d2(2'b11, 1'b0, 13'd8, 64'h0, 13'd8, 2'b01, 2'b00, ERR ? C2 : E2, 1'b0, "rst grant");
    req2 = '0;
    rst_n = 1'b0;
    #2;
    chk("mid-reset rvalid2", 64'(rvalid2), 64'd0);
    chk("mid-reset rdata2", rdata2[63:0], 64'h0);
    chk("mid-reset rdata", rdata[63:0], 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("discarded rvalid2", 64'(rvalid2), 64'd0);
    chk("discarded rvalid", 64'(rvalid), 64'd0);

    req = 2'b11; we = '0; be = 16'hFFFF; addr = {12'd8, 12'd8};
    req2 = 2'b11; we2 = '0; be2 = 16'hFFFF; addr2 = {13'd8, 13'd8};
    @(negedge clk);
    chk("post-reset gnt", 64'(gnt), 64'd1);
    chk("post-reset gnt2", 64'(gnt2), 64'd1);
    @(posedge clk); #1;
    req = '0; req2 = '0;
    chk("post-reset rvalid", 64'(rvalid), 64'd1);
    chk("post-reset rdata kept mem", rdata[63:0], D8);
    chk("post-reset rvalid2 early", 64'(rvalid2), 64'd0);
    @(posedge clk); #1;
    chk("post-reset rvalid2", 64'(rvalid2), 64'd1);
    chk("post-reset rvalid idle", 64'(rvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
